// File: rtl/sym_stats_collector.sv
// rtl/sym_stats_collector.sv - saturating statistics over the symmetry detector result stream
module sym_stats_collector #(
  parameter int WORD_W     = 8,
  parameter int MM_W       = 3,
  parameter int CNT_W      = 16,
  parameter int RUN_W      = 8,
  parameter int RUN_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sym,
  input  logic [MM_W-1:0]  in_mismatch,
  input  logic             clear,
  input  logic             freeze,
  input  logic [3:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             streak_flag
);

  localparam int HALF  = WORD_W / 2;
  localparam int NBINS = HALF + 1;
  localparam logic [MM_W-1:0]  MM_MAX = MM_W'(HALF);
  localparam logic [RUN_W-1:0] THRESH = RUN_W'(RUN_THRESH);

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_CLR} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] total_cnt, sym_cnt, err_cnt;
  logic [CNT_W-1:0] hist [NBINS];
  logic [RUN_W-1:0] cur_run, max_run, cur_run_nxt;
  logic [CNT_W-1:0] rd_mux;
  logic             accept, malformed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (clear) state_nxt = S_CLR; else if (freeze) state_nxt = S_HOLD;
      S_HOLD:  if (clear) state_nxt = S_CLR; else if (!freeze) state_nxt = S_RUN;
      S_CLR:   state_nxt = freeze ? S_HOLD : S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // clear and freeze outrank a pending beat combinationally, so neither can sneak one in
  assign in_ready  = (state == S_RUN) && !clear && !freeze && !rst;
  assign accept    = in_valid && in_ready;
  assign malformed = (in_mismatch > MM_MAX) || (in_sym != (in_mismatch == '0));

  always_comb begin
    cur_run_nxt = cur_run;
    if (accept) begin
      if (malformed || !in_sym)  cur_run_nxt = '0;
      else if (cur_run != '1)    cur_run_nxt = cur_run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cnt   <= '0;
      sym_cnt     <= '0;
      err_cnt     <= '0;
      cur_run     <= '0;
      max_run     <= '0;
      streak_flag <= 1'b0;
      for (int b = 0; b < NBINS; b++) hist[b] <= '0;
    end else if (clear) begin
      total_cnt   <= '0;
      sym_cnt     <= '0;
      err_cnt     <= '0;
      cur_run     <= '0;
      max_run     <= '0;
      streak_flag <= 1'b0;
      for (int b = 0; b < NBINS; b++) hist[b] <= '0;
    end else if (accept) begin
      total_cnt   <= sat_inc(total_cnt);
      cur_run     <= cur_run_nxt;
      streak_flag <= (cur_run_nxt >= THRESH);
      if (malformed) begin
        err_cnt <= sat_inc(err_cnt);
      end else begin
        for (int b = 0; b < NBINS; b++)
          if (in_mismatch == MM_W'(b)) hist[b] <= sat_inc(hist[b]);
        if (in_sym) begin
          sym_cnt <= sat_inc(sym_cnt);
          if (cur_run_nxt > max_run) max_run <= cur_run_nxt;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      4'd0:    rd_mux = total_cnt;
      4'd1:    rd_mux = sym_cnt;
      4'd7:    rd_mux = CNT_W'(cur_run);
      4'd8:    rd_mux = CNT_W'(max_run);
      4'd9:    rd_mux = err_cnt;
      default: rd_mux = '0;
    endcase
    for (int b = 0; b < NBINS; b++)
      if (rd_sel == 4'(2 + b)) rd_mux = hist[b];
  end

  // readout runs in every state so a frozen snapshot can be swept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_sym_stats_collector.sv
// tb/tb_sym_stats_collector.sv - directed scoreboard bench for sym_stats_collector
module tb_sym_stats_collector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_sym, clear, freeze, streak_flag;
  logic [2:0]  in_mismatch;
  logic [3:0]  rd_sel;
  logic [15:0] rd_data;

  logic        s_rst, s_valid, s_ready, s_sym, s_clear, s_freeze, s_streak;
  logic [2:0]  s_mm;
  logic [3:0]  s_sel;
  logic [3:0]  s_rd_data;

  sym_stats_collector u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .in_mismatch(in_mismatch), .clear(clear), .freeze(freeze), .rd_sel(rd_sel),
    .rd_data(rd_data), .streak_flag(streak_flag)
  );

  sym_stats_collector #(.CNT_W(4), .RUN_W(4)) u_sat (
    .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_ready(s_ready), .in_sym(s_sym),
    .in_mismatch(s_mm), .clear(s_clear), .freeze(s_freeze), .rd_sel(s_sel),
    .rd_data(s_rd_data), .streak_flag(s_streak)
  );

  int total_n = 0;
  int bad_n   = 0;

  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t sbq[$];

  localparam int unsigned MAXC = 65535;
  localparam int unsigned MAXR = 255;
  int unsigned m_total, m_sym, m_err, m_cur, m_max;
  int unsigned m_hist[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_zero();
    m_total = 0; m_sym = 0; m_err = 0; m_cur = 0; m_max = 0;
    for (int i = 0; i < 5; i++) m_hist[i] = 0;
  endtask

  task automatic m_accept(input logic sym, input logic [2:0] mm);
    if (m_total < MAXC) m_total++;
    if (mm > 3'd4 || sym != (mm == 3'd0)) begin
      if (m_err < MAXC) m_err++;
      m_cur = 0;
    end else begin
      if (m_hist[mm] < MAXC) m_hist[mm]++;
      if (sym) begin
        if (m_sym < MAXC) m_sym++;
        if (m_cur < MAXR) m_cur++;
        if (m_cur > m_max) m_max = m_cur;
      end else begin
        m_cur = 0;
      end
    end
  endtask

  function automatic logic [31:0] m_stat(input int sel);
    case (sel)
      0: return m_total;
      1: return m_sym;
      2, 3, 4, 5, 6: return m_hist[sel-2];
      7: return m_cur;
      8: return m_max;
      9: return m_err;
      default: return 0;
    endcase
  endfunction

  // all tasks start and end one time unit after a rising edge
  task automatic rd(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    rd_sel = 4'(sel);
    sbq.push_back('{tag, exp});
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk(e.tag, {16'd0, rd_data}, e.exp);
  endtask

  task automatic rd_all(input string tag);
    for (int s = 0; s < 16; s++) rd($sformatf("%s_sel%0d", tag, s), s, m_stat(s));
  endtask

  task automatic s_rd(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    s_sel = 4'(sel);
    sbq.push_back('{tag, exp});
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk(e.tag, {28'd0, s_rd_data}, e.exp);
  endtask

  task automatic beat(input string tag, input logic sym, input logic [2:0] mm);
    int n;
    logic rdy;
    in_valid = 1'b1; in_sym = sym; in_mismatch = mm; n = 0;
    #1;
    while (!in_ready && n < 20) begin @(posedge clk); #2; n++; end
    rdy = in_ready;
    chk({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    if (rdy) m_accept(sym, mm);
    in_valid = 1'b0;
  endtask

  task automatic clear_stats(input string tag);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_zero();
    chk({tag, "_streak"}, {31'd0, streak_flag}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sweep[5];
    sweep = '{0, 1, 2, 7, 9};
    rst = 1'b1; in_valid = 1'b0; in_sym = 1'b0; in_mismatch = '0; clear = 1'b0; freeze = 1'b0; rd_sel = '0;
    s_rst = 1'b1; s_valid = 1'b0; s_sym = 1'b0; s_mm = '0; s_clear = 1'b0; s_freeze = 1'b0; s_sel = '0;
    m_zero();
    #2;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst_streak", {31'd0, streak_flag}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; s_rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // 1: basic accumulation
    for (int i = 0; i < 3; i++) beat("t1_sym", 1'b1, 3'd0);
    beat("t1_asym", 1'b0, 3'd2);
    rd("t1_total", 0, 4);
    rd("t1_sym", 1, 3);
    rd("t1_hist0", 2, 3);
    rd("t1_hist2", 4, 1);
    rd("t1_cur", 7, 0);
    rd("t1_max", 8, 3);
    rd("t1_err", 9, 0);

    // 2: streak flag
    clear_stats("t2_clr");
    for (int i = 0; i < 6; i++) begin
      beat($sformatf("t2_b%0d", i), 1'b1, 3'd0);
      chk($sformatf("t2_streak%0d", i), {31'd0, streak_flag}, (i >= 3) ? 32'd1 : 32'd0);
    end
    beat("t2_break", 1'b0, 3'd1);
    chk("t2_streak_drop", {31'd0, streak_flag}, 32'd0);
    rd("t2_cur", 7, 0);
    rd("t2_max", 8, 6);

    // 3: malformed results
    clear_stats("t3_clr");
    beat("t3_m1", 1'b1, 3'd1);
    beat("t3_m2", 1'b0, 3'd5);
    rd("t3_err", 9, 2);
    rd("t3_total", 0, 2);
    rd_all("t3");

    // 4: freeze with a pending beat
    freeze = 1'b1; in_valid = 1'b1; in_sym = 1'b1; in_mismatch = 3'd0;
    #1;
    chk("t4_ready_freeze", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_ready%0d", i), {31'd0, in_ready}, 32'd0);
      rd($sformatf("t4_hold_sel%0d", sweep[i]), sweep[i], m_stat(sweep[i]));
    end
    freeze = 1'b0;
    beat("t4_release", 1'b1, 3'd0);
    @(posedge clk); #1;
    rd("t4_total", 0, 3);
    rd("t4_cur", 7, 1);

    // 5: clear collides with a valid beat
    while (m_total < 10) beat("t5_fill", 1'b1, 3'd0);
    rd("t5_total10", 0, 10);
    in_valid = 1'b1; in_sym = 1'b1; in_mismatch = 3'd0; clear = 1'b1;
    #1;
    chk("t5_ready_clear", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    m_zero();
    chk("t5_streak", {31'd0, streak_flag}, 32'd0);
    rd_all("t5");
    beat("t5_after", 1'b1, 3'd0);
    rd("t5_total1", 0, 1);

    // 6: saturation build and async reset
    s_valid = 1'b1; s_sym = 1'b1; s_mm = 3'd0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t6_ready%0d", i), {31'd0, s_ready}, 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_rd("t6_total", 0, 15);
    s_rd("t6_sym", 1, 15);
    s_rd("t6_hist0", 2, 15);
    s_rd("t6_cur", 7, 15);
    s_rd("t6_max", 8, 15);
    s_rd("t6_err", 9, 0);
    chk("t6_streak", {31'd0, s_streak}, 32'd1);
    s_valid = 1'b1;
    #3;
    s_rst = 1'b1;
    #1;
    chk("t6_rst_ready", {31'd0, s_ready}, 32'd0);
    chk("t6_rst_rd", {28'd0, s_rd_data}, 32'd0);
    chk("t6_rst_streak", {31'd0, s_streak}, 32'd0);
    @(posedge clk); #1;
    s_rst = 1'b0; s_valid = 1'b0;
    for (int s = 0; s < 10; s++) s_rd($sformatf("t6_zero_sel%0d", s), s, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
